// File: rtl/quire_window_arbiter_pkg.sv
// Shared types and width helpers for the quire window arbiter.
// Widths follow the decoded-posit layout: hidden bit plus fraction, doubled for products.
package quire_window_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } quire_arb_state_t;

  function automatic int fraction_width(input int pw, input int es, input int is_prod);
    int fw;
    fw = pw - es - 2;
    return (is_prod != 0) ? 2 * fw : fw;
  endfunction

  function automatic int scale_width(input int pw, input int es, input int is_prod);
    int sw;
    sw = $clog2(pw) + es + 1;
    return (is_prod != 0) ? sw + 1 : sw;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/quire_window_arbiter_id_fifo.sv
// Small ID FIFO recording which requester owns each window in flight in the quire.
// Push while full and pop while empty are ignored; the owner flags them as errors.
module arb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/quire_window_arbiter.sv
// Window-granular round-robin arbiter sharing one quire between NUM_REQ requesters.
// Each granted window's owner ID is queued so quire results leave tagged with it.
module quire_window_arbiter
  import quire_window_arbiter_pkg::*;
#(
  parameter int POSIT_WIDTH   = 4,
  parameter int POSIT_ES      = 0,
  parameter int IS_PROD_ACCUM = 1,
  parameter int NUM_REQ       = 4,
  parameter int ID_FIFO_DEPTH = 4,
  localparam int FW  = fraction_width(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM),
  localparam int SW  = scale_width(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM),
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_rts_i,
  output logic [NUM_REQ-1:0]    req_rtr_o,
  input  logic [NUM_REQ-1:0]    req_sow_i,
  input  logic [NUM_REQ-1:0]    req_eow_i,
  input  logic [NUM_REQ-1:0]    req_sign_i,
  input  logic [NUM_REQ-1:0]    req_zero_i,
  input  logic [NUM_REQ-1:0]    req_NaR_i,
  input  logic [NUM_REQ*FW-1:0] req_fraction_i,
  input  logic [NUM_REQ*SW-1:0] req_scale_i,
  output logic                  q_rts_o,
  input  logic                  q_rtr_i,
  output logic                  q_sow_o,
  output logic                  q_eow_o,
  output logic                  q_sign_o,
  output logic                  q_zero_o,
  output logic                  q_NaR_o,
  output logic [FW-1:0]         q_fraction_o,
  output logic [SW-1:0]         q_scale_o,
  input  logic                  res_rts_i,
  input  logic                  res_eow_i,
  output logic                  res_rtr_o,
  output logic                  out_rts_o,
  input  logic                  out_rtr_i,
  output logic [IDW-1:0]        out_id_o,
  output logic                  err_o
);

  localparam int CW = $clog2(ID_FIFO_DEPTH) + 1;

  quire_arb_state_t state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             beat_seen_q, beat_seen_d;
  logic             err_q;
  logic             pick_valid;
  logic [IDW-1:0]   pick_id;
  logic             push;
  logic             extra_sow;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    frac_arr [NUM_REQ];
  logic [SW-1:0]    scale_arr [NUM_REQ];

  // Scan starts just after the last winner; the lowest offset wins, so scan downward.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                           input logic [IDW-1:0] ptr);
    logic [IDW:0]   r;
    logic [IDW-1:0] k;
    r = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IDW'((int'(ptr) + i) % NUM_REQ);
      if (cand[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign frac_arr[g]  = req_fraction_i[g*FW +: FW];
    assign scale_arr[g] = req_scale_i[g*SW +: SW];
  end

  assign q_sow_o      = req_sow_i[grant_q];
  assign q_eow_o      = req_eow_i[grant_q];
  assign q_sign_o     = req_sign_i[grant_q];
  assign q_zero_o     = req_zero_i[grant_q];
  assign q_NaR_o      = req_NaR_i[grant_q];
  assign q_fraction_o = frac_arr[grant_q];
  assign q_scale_o    = scale_arr[grant_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_seen_d = beat_seen_q;
    req_rtr_o   = '0;
    q_rts_o     = 1'b0;
    push        = 1'b0;
    extra_sow   = 1'b0;
    {pick_valid, pick_id} = rr_pick(req_rts_i & req_sow_i, rr_ptr_q);
    case (state_q)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          grant_d     = pick_id;
          beat_seen_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        q_rts_o            = req_rts_i[grant_q];
        req_rtr_o[grant_q] = q_rtr_i;
        if (req_rts_i[grant_q] && q_rtr_i) begin
          beat_seen_d = 1'b1;
          push        = req_sow_i[grant_q];
          extra_sow   = req_sow_i[grant_q] && beat_seen_q;
          if (req_eow_i[grant_q]) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      beat_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_seen_q <= beat_seen_d;
      err_q       <= err_q | extra_sow | (pop_req & fifo_empty);
    end
  end

  assign pop_req   = res_rts_i & out_rtr_i & res_eow_i;
  assign out_rts_o = res_rts_i;
  assign res_rtr_o = out_rtr_i;
  assign err_o     = err_q;

  arb_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (grant_q),
    .pop   (pop_req),
    .head  (out_id_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_quire_window_arbiter.sv
// Directed bench for quire_window_arbiter: a vector table for a single window plus
// hand-written sequences for round-robin, stalls, FIFO full, errors and async reset.
module tb_quire_window_arbiter;
  import quire_window_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int FW  = fraction_width(4, 0, 1);
  localparam int SW  = scale_width(4, 0, 1);
  localparam int IDW = id_width(NR);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_rts_i, req_rtr_o, req_sow_i, req_eow_i;
  logic [NR-1:0]   req_sign_i, req_zero_i, req_NaR_i;
  logic [NR*FW-1:0] req_fraction_i;
  logic [NR*SW-1:0] req_scale_i;
  logic            q_rts_o, q_rtr_i, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o;
  logic [FW-1:0]   q_fraction_o;
  logic [SW-1:0]   q_scale_o;
  logic            res_rts_i, res_eow_i, res_rtr_o, out_rts_o, out_rtr_i, err_o;
  logic [IDW-1:0]  out_id_o;
  logic [FW-1:0]   frac [NR];
  logic [SW-1:0]   scl [NR];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_fraction_i[g*FW +: FW] = frac[g];
    assign req_scale_i[g*SW +: SW]    = scl[g];
  end

  quire_window_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_rts_i(req_rts_i), .req_rtr_o(req_rtr_o),
    .req_sow_i(req_sow_i), .req_eow_i(req_eow_i),
    .req_sign_i(req_sign_i), .req_zero_i(req_zero_i), .req_NaR_i(req_NaR_i),
    .req_fraction_i(req_fraction_i), .req_scale_i(req_scale_i),
    .q_rts_o(q_rts_o), .q_rtr_i(q_rtr_i),
    .q_sow_o(q_sow_o), .q_eow_o(q_eow_o), .q_sign_o(q_sign_o),
    .q_zero_o(q_zero_o), .q_NaR_o(q_NaR_o),
    .q_fraction_o(q_fraction_o), .q_scale_o(q_scale_o),
    .res_rts_i(res_rts_i), .res_eow_i(res_eow_i), .res_rtr_o(res_rtr_o),
    .out_rts_o(out_rts_o), .out_rtr_i(out_rtr_i), .out_id_o(out_id_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_rts_i = '0; req_sow_i = '0; req_eow_i = '0;
    req_sign_i = '0; req_zero_i = '0; req_NaR_i = '0;
    for (int k = 0; k < NR; k++) begin
      frac[k] = '0;
      scl[k]  = '0;
    end
    q_rtr_i = 1'b0; res_rts_i = 1'b0; res_eow_i = 1'b0; out_rtr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NR-1:0] rts, sow, eow;
    logic          q_rtr;
    logic [FW-1:0] frac;
    logic [NR-1:0] e_req_rtr;
    logic          e_q_rts, e_q_sow, e_q_eow;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int b, stall;
    logic xfer;
    logic [FW-1:0] rx [$];
    logic [NR-1:0] exp_rr [6];
    logic [IDW-1:0] exp_ids [4];

    vecs[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'h5, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'h5, 4'b0100, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'h6, 4'b0100, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'h9, 4'b0100, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_req_rtr", 32'(req_rtr_o), 32'h0);
    chk("rst_q_rts", 32'(q_rts_o), 32'h0);
    chk("rst_out_id", 32'(out_id_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_count", 32'(dut.fifo_count), 32'h0);
    step();

    // Requester 2 sends a 3-beat window; other requesters carry inverted data.
    for (int i = 0; i < 5; i++) begin
      req_rts_i = vecs[i].rts; req_sow_i = vecs[i].sow; req_eow_i = vecs[i].eow;
      q_rtr_i   = vecs[i].q_rtr;
      for (int k = 0; k < NR; k++) begin
        frac[k] = (k == 2) ? vecs[i].frac : ~vecs[i].frac;
        scl[k]  = (k == 2) ? SW'(vecs[i].frac + 4'h1) : '0;
      end
      @(negedge clk);
      chk($sformatf("v%0d_req_rtr", i), 32'(req_rtr_o), 32'(vecs[i].e_req_rtr));
      chk($sformatf("v%0d_q_rts", i), 32'(q_rts_o), 32'(vecs[i].e_q_rts));
      if (vecs[i].e_q_rts) begin
        chk($sformatf("v%0d_q_sow", i), 32'(q_sow_o), 32'(vecs[i].e_q_sow));
        chk($sformatf("v%0d_q_eow", i), 32'(q_eow_o), 32'(vecs[i].e_q_eow));
        chk($sformatf("v%0d_q_frac", i), 32'(q_fraction_o), 32'(vecs[i].frac));
        chk($sformatf("v%0d_q_scale", i), 32'(q_scale_o), 32'(SW'(vecs[i].frac + 4'h1)));
      end
      step();
    end
    res_rts_i = 1'b1; res_eow_i = 1'b1; out_rtr_i = 1'b1;
    @(negedge clk);
    chk("res_out_rts", 32'(out_rts_o), 32'h1);
    chk("res_rtr", 32'(res_rtr_o), 32'h1);
    chk("res_out_id", 32'(out_id_o), 32'h2);
    step();
    res_rts_i = 1'b0; res_eow_i = 1'b0; out_rtr_i = 1'b0;
    @(negedge clk);
    chk("res_count_empty", 32'(dut.fifo_count), 32'h0);
    chk("res_err", 32'(err_o), 32'h0);

    // Round robin: 0 and 1 both present single-beat windows out of reset.
    do_reset();
    exp_rr = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    req_rts_i = 4'b0011; req_sow_i = 4'b0011; req_eow_i = 4'b0011; q_rtr_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_req_rtr", i), 32'(req_rtr_o), 32'(exp_rr[i]));
      step();
    end

    // Quire stalls for 5 cycles on beat 1 of a requester-3 window.
    do_reset();
    b = 0; stall = 0; rx.delete();
    for (int cyc = 0; cyc < 40 && b < 3; cyc++) begin
      req_rts_i = 4'b1000;
      req_sow_i = (b == 0) ? 4'b1000 : 4'b0000;
      req_eow_i = (b == 2) ? 4'b1000 : 4'b0000;
      frac[3]   = FW'(b + 1);
      q_rtr_i   = (b == 1 && stall < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!q_rtr_i && q_rts_o) begin
        stall++;
        chk("stall_hold_frac", 32'(q_fraction_o), 32'h2);
      end
      xfer = q_rts_o && q_rtr_i;
      if (xfer) rx.push_back(q_fraction_o);
      step();
      if (xfer) b++;
    end
    chk("stall_cycles", 32'(stall), 32'd5);
    chk("stall_beats", 32'(rx.size()), 32'd3);
    for (int i = 0; i < rx.size(); i++)
      chk($sformatf("stall_beat%0d", i), 32'(rx[i]), 32'(i + 1));

    // Result path blocked: four single-beat windows fill the ID FIFO.
    do_reset();
    req_rts_i = 4'b1111; req_sow_i = 4'b1111; req_eow_i = 4'b1111; q_rtr_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk($sformatf("fill%0d_idle", w), 32'(req_rtr_o), 32'h0);
      step();
      @(negedge clk);
      chk($sformatf("fill%0d_grant", w), 32'(req_rtr_o), 32'(1 << w));
      step();
    end
    @(negedge clk);
    chk("full_count", 32'(dut.fifo_count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("full_hold%0d", i), 32'(req_rtr_o), 32'h0);
      step();
    end
    res_rts_i = 1'b1; res_eow_i = 1'b1; out_rtr_i = 1'b1;
    @(negedge clk);
    chk("full_pop_id", 32'(out_id_o), 32'h0);
    chk("full_pop_idle", 32'(req_rtr_o), 32'h0);
    step();
    res_rts_i = 1'b0; res_eow_i = 1'b0; out_rtr_i = 1'b0;
    @(negedge clk);
    chk("after_pop_idle", 32'(req_rtr_o), 32'h0);
    step();
    @(negedge clk);
    chk("after_pop_grant", 32'(req_rtr_o), 32'h1);
    step();
    req_rts_i = '0; req_sow_i = '0; req_eow_i = '0;
    exp_ids = '{2'd1, 2'd2, 2'd3, 2'd0};
    res_rts_i = 1'b1; res_eow_i = 1'b1; out_rtr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pop%0d_id", i), 32'(out_id_o), 32'(exp_ids[i]));
      step();
    end
    res_rts_i = 1'b0; res_eow_i = 1'b0; out_rtr_i = 1'b0;
    @(negedge clk);
    chk("drain_count", 32'(dut.fifo_count), 32'h0);
    chk("drain_err", 32'(err_o), 32'h0);

    // Extra sow on the second beat of a grant.
    do_reset();
    req_rts_i = 4'b0010; req_sow_i = 4'b0010; q_rtr_i = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("xsow_err_b0", 32'(err_o), 32'h0);
    step();
    @(negedge clk);
    chk("xsow_err_b1", 32'(err_o), 32'h0);
    step();
    req_sow_i = '0; req_eow_i = 4'b0010;
    @(negedge clk);
    chk("xsow_err_set", 32'(err_o), 32'h1);
    step();
    req_rts_i = '0; req_eow_i = '0;
    repeat (3) step();
    @(negedge clk);
    chk("xsow_err_sticky", 32'(err_o), 32'h1);

    // Result eow with nothing in flight.
    do_reset();
    @(negedge clk);
    chk("epop_err_before", 32'(err_o), 32'h0);
    res_rts_i = 1'b1; res_eow_i = 1'b1; out_rtr_i = 1'b1;
    step();
    res_rts_i = 1'b0; res_eow_i = 1'b0; out_rtr_i = 1'b0;
    @(negedge clk);
    chk("epop_err_set", 32'(err_o), 32'h1);
    chk("epop_count", 32'(dut.fifo_count), 32'h0);
    repeat (3) step();
    @(negedge clk);
    chk("epop_err_sticky", 32'(err_o), 32'h1);

    // Asynchronous reset in the middle of a window.
    do_reset();
    req_rts_i = 4'b0100; req_sow_i = 4'b0100; q_rtr_i = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("mid_busy", 32'(req_rtr_o), 32'h4);
    step();
    req_sow_i = '0;
    @(negedge clk);
    chk("mid_count", 32'(dut.fifo_count), 32'h1);
    chk("mid_head", 32'(out_id_o), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_rtr", 32'(req_rtr_o), 32'h0);
    chk("arst_q_rts", 32'(q_rts_o), 32'h0);
    chk("arst_count", 32'(dut.fifo_count), 32'h0);
    chk("arst_out_id", 32'(out_id_o), 32'h0);
    chk("arst_err", 32'(err_o), 32'h0);
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quire_window_arbiter.md
Name: quire_window_arbiter

Overview:
- Shares one product-accumulate pipeline (quire) between NUM_REQ upstream requesters, each streaming windows of decoded products framed by sow/eow.
- Arbitration granularity is one whole window: a grant lasts from the sow beat to the eow beat, so a quire accumulation never interleaves two requesters.
- A small ID FIFO remembers window ownership so that each quire result (eow beat) is tagged with its requester ID.
- Sits between the multipliers/decoders and the quire; the quire data output goes straight to the consumer, and only handshake/ID sideband passes through this block.

Parameters:
- POSIT_WIDTH, 4, posit width of the shared datapath.
- POSIT_ES, 0, posit exponent size.
- IS_PROD_ACCUM, 1, 1 means inputs are products (fraction and scale widths per package macros).
- NUM_REQ, 4, number of requesters (2..16).
- ID_FIFO_DEPTH, 4, maximum number of windows in flight inside the quire (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_rts_i  in  NUM_REQ  per-requester ready-to-send
- req_rtr_o  out  NUM_REQ  per-requester ready-to-receive
- req_sow_i, req_eow_i, req_sign_i, req_zero_i, req_NaR_i  in  NUM_REQ each  per-requester flags
- req_fraction_i  in  NUM_REQ*FW  flattened fractions, requester k at [k*FW +: FW]
- req_scale_i  in  NUM_REQ*SW  flattened signed scales
- q_rts_o  out  1  to quire rts_i
- q_rtr_i  in  1  from quire rtr_o
- q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o  out  1  muxed flags
- q_fraction_o  out  FW  muxed fraction
- q_scale_o  out  SW  muxed scale
- res_rts_i  in  1  quire rts_o
- res_eow_i  in  1  quire eow_o
- res_rtr_o  out  1  to quire rtr_i
- out_rts_o  out  1  result valid to consumer
- out_rtr_i  in  1  consumer ready
- out_id_o  out  IDW  requester owning current result, IDW = max(1, clog2(NUM_REQ))
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - state IDLE, grant_id 0, rr_ptr NUM_REQ-1 (requester 0 has first priority).
  - FIFO empty, err_o 0, req_rtr_o all 0, q_rts_o 0, out_id_o 0.
- Transfer rule: a beat transfers when rts & rtr are both high at a rising edge.
- FSM states:
  - IDLE:
    - req_rtr_o = 0 and q_rts_o = 0.
    - Candidates: requesters with req_rts_i[k] & req_sow_i[k].
    - Winner: first candidate scanning from rr_ptr+1 modulo NUM_REQ.
    - If a candidate exists and the FIFO is not full, register grant_id = winner and go to BUSY next cycle.
    - A requester presenting rts without sow in IDLE is never granted (held off).
  - BUSY:
    - q_* outputs = the granted requester's inputs (combinational mux).
    - q_rts_o = req_rts_i[grant_id].
    - req_rtr_o[grant_id] = q_rtr_i; all other bits 0.
    - On transfer of a beat with sow=1, push grant_id into the FIFO.
    - On transfer of a beat with eow=1, set rr_ptr <= grant_id and go to IDLE.
    - A sow=1 beat after the first beat of a grant sets err_o; the beat is still forwarded.
- Arbitration cost: minimum one IDLE cycle between consecutive windows.
- Single-beat window (sow and eow in the same beat): push and return to IDLE in the same cycle.
- Result path:
  - out_rts_o = res_rts_i.
  - res_rtr_o = out_rtr_i.
  - out_id_o = FIFO head.
  - Pop on res_rts_i & out_rtr_i & res_eow_i.
  - A pop while the FIFO is empty sets err_o; the FIFO stays empty.
- Full/empty:
  - The grant check uses the registered count, so a window is granted only if a slot is free.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo ID_FIFO_DEPTH.
- Reset mid-window: returns to IDLE with the FIFO empty. Any partial window in the quire is discarded by the upstream restart; no recovery is attempted.
- err_o clears only on reset.

Decomposition:
- posit_defines package: add a quire_arb_state_t enum {IDLE, BUSY}; reuse the FRACTION_WIDTH and SCALE_WIDTH macros.
- Sub-module arb_id_fifo (parameterised width/depth, push/pop/full/empty/head, async active-low reset).
- The round-robin picker stays inline as a function.

Test Plan:
- Requester 2 alone sends a 3-beat window (sow on beat 0, eow on beat 2), q_rtr_i=1:
  - req_rtr_o=4'b0100 only during BUSY.
  - q_* mirror requester 2 beat by beat.
  - Result eow produces out_id_o=2 with the FIFO then empty.
- Requesters 0 and 1 both present sow out of reset:
  - 0 granted first, then 1 (one IDLE gap).
  - Then 0 again while both keep requesting, proving round-robin.
- q_rtr_i stalled for 5 cycles mid-window:
  - requester data holds, no beat lost or duplicated.
  - Beat count at the quire equals beats sent.
- res_rtr path blocked so 4 single-beat windows fill the FIFO:
  - a fifth sow is not granted (req_rtr_o=0) until one result pop.
  - IDs are popped in grant order.
- Extra sow mid-grant, and a result eow with the FIFO empty: err_o rises and stays 1.
- rst_n asserted during BUSY: outputs return to reset values immediately and the FIFO count is 0.
